fooladi_farbod_98243045_question1: RTL and testbench
====================================================

Name: fooladi_farbod_98243045_question1

Overview:
Registered 4-variable combinational logic cell. It evaluates the fixed switching function F(a,b,c,d) = Σm(0,2,3,5,7,8,10,11,13,15) from externally supplied true and complemented literals, and registers the result. It also flags literal pairs that are not complementary. It serves as a standalone gate-level exercise block: upstream logic provides both polarities of each variable, so the block contains no internal inverters on the data path.

Parameters:
None. The function is fixed.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
out  output 1  registered value of F
a  input  1  variable a (MSB of minterm index)
b  input  1  variable b
c  input  1  variable c
d  input  1  variable d (LSB of minterm index)
not_a  input  1  complement literal of a
not_b  input  1  complement literal of b
not_c  input  1  complement literal of c
not_d  input  1  complement literal of d
err  output 1  registered literal-inconsistency flag

Behaviour:
- Minterm index is {a,b,c,d}. a is the MSB.
- F = 1 for minterms 0,2,3,5,7,8,10,11,13,15.
- F = 0 for minterms 1,4,6,9,12,14.
- Minimal SOP: F = not_b·not_d + b·d + not_b·c.
- Implementation rules for F:
  - Build F as a two-level AND-OR or NAND-NAND network.
  - Use only the port literals. Do not derive a complement internally from its true input.
  - Since the minimal SOP uses only b, c, d and their complements, a/not_a appear only in the consistency check.
- Consistency per pair (x, not_x): the pair is valid when x != not_x.
  - bad = (a==not_a) | (b==not_b) | (c==not_c) | (d==not_d).
- Sequential behaviour, all updates on the rising edge of clk:
  - rst=1: out <= 0, err <= 0. Reset has priority over all inputs.
  - rst=0 and bad=0: out <= F, err <= 0.
  - rst=0 and bad=1: out <= 0, err <= 1. The output is forced to 0 whenever err is asserted.
- Latency: exactly 1 clock from stable inputs to out/err.
- No combinational path from inputs to outputs.
- Inputs changing mid-cycle have no effect until the next rising edge. No input registering beyond the output flops.
- Reset asserted mid-operation clears both outputs at the next edge. The first evaluation happens on the first edge with rst=0.
- No X-propagation handling is required. Reset defines all state.

Test Plan:
- Reset: rst=1 for 2 edges with a..d=1111 and valid complements -> out=0, err=0. Release rst; the next edge gives out=1 (m15).
- Exhaustive sweep: apply minterms 0..15 with valid complements, one per clock. out one cycle later must be 1,0,1,1,0,1,0,1,1,0,1,1,0,1,0,1, with err=0 throughout.
- Don't-care on a: {a,b,c,d}=0001 vs 1001 -> out=0 for both. 0010 vs 1010 -> out=1 for both.
- Inconsistent literals: b=1, not_b=1, other pairs valid, abcd=0101 -> next edge err=1, out=0. Restore not_b=0 -> next edge err=0, out=1.
- Latency/hold: change inputs from 0000 to 0100 between edges -> out stays 1 until the next rising edge, then becomes 0.
- Mid-run reset: during the sweep at minterm 7 (out=1), assert rst for one edge -> out=0, err=0. Resume after release.

Source files
------------

// File: rtl/fooladi_farbod_98243045_question1.sv
// Registered 4-variable logic cell.
// Computes F(a,b,c,d) = sum m(0,2,3,5,7,8,10,11,13,15) as a two-level AND-OR
// network on externally supplied literals. Also flags any literal pair whose
// true and complement inputs agree. Both results are registered, and out is
// forced low while the inconsistency flag is set.
module fooladi_farbod_98243045_question1 (
  input  logic clk,
  input  logic rst,
  output logic out,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic not_a,
  input  logic not_b,
  input  logic not_c,
  input  logic not_d,
  output logic err
);

  // Product terms of the minimal SOP. Only the port literals are used, so
  // there are no inverters on the data path.
  logic term_bd_n_s;   // not_b & not_d
  logic term_bd_s;     // b & d
  logic term_bc_s;     // not_b & c
  logic f_s;
  logic bad_s;

  logic out_d, out_q;
  logic err_d, err_q;

  assign term_bd_n_s = not_b & not_d;
  assign term_bd_s   = b & d;
  assign term_bc_s   = not_b & c;
  assign f_s         = term_bd_n_s | term_bd_s | term_bc_s;

  // A pair is inconsistent when its true and complement literals are equal.
  // Only this check uses a and not_a; F does not depend on a.
  assign bad_s = ~(a ^ not_a) | ~(b ^ not_b) | ~(c ^ not_c) | ~(d ^ not_d);

  // Next-state selection: report an error and force out low on bad literals.
  always_comb begin
    out_d = 1'b0;
    err_d = 1'b0;
    if (bad_s) begin
      out_d = 1'b0;
      err_d = 1'b1;
    end else begin
      out_d = f_s;
      err_d = 1'b0;
    end
  end

  // Output registers with synchronous active-high reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign out = out_q;
  assign err = err_q;

endmodule

// File: tb/tb_fooladi_farbod_98243045_question1.sv
// Self-checking bench for fooladi_farbod_98243045_question1.
// Runs a table of directed vectors, hand-written latency, hold and reset
// sequences, and randomized stimulus checked against a minterm-list model.
module tb_fooladi_farbod_98243045_question1;

  logic clk;
  logic rst;
  logic out;
  logic a, b, c, d;
  logic not_a, not_b, not_c, not_d;
  logic err;

  int vectors;
  int miscompares;

  fooladi_farbod_98243045_question1 dut (
    .clk   (clk),
    .rst   (rst),
    .out   (out),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .not_a (not_a),
    .not_b (not_b),
    .not_c (not_c),
    .not_d (not_d),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] abcd;
    logic [3:0] nabcd;
    logic       exp_out;
    logic       exp_err;
  } vec_t;

  vec_t tbl[$];

  // Function on-set, taken directly from the minterm list.
  int on_set[10] = '{0, 2, 3, 5, 7, 8, 10, 11, 13, 15};

  function automatic logic model_f(input logic [3:0] idx);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 10; k++)
      if (int'(idx) == on_set[k]) r = 1'b1;
    return r;
  endfunction

  // A pair is bad when the true and complement bits are equal.
  function automatic logic model_bad(input logic [3:0] v, input logic [3:0] nv);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 4; k++)
      if (v[k] == nv[k]) r = 1'b1;
    return r;
  endfunction

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] nv);
    rst = r;
    {a, b, c, d} = v;
    {not_a, not_b, not_c, not_d} = nv;
  endtask

  task automatic check(input string name, input logic eo, input logic ee);
    vectors++;
    if (out !== eo || err !== ee) begin
      miscompares++;
      $display("FAIL %s: got out=%0b err=%0b, expected out=%0b err=%0b",
               name, out, err, eo, ee);
    end
  endtask

  // Wait for the active edge, then sample 1 time unit later.
  task automatic step_check(input string name, input logic eo, input logic ee);
    @(posedge clk);
    #1;
    check(name, eo, ee);
  endtask

  function automatic void add(input string n, input logic r, input logic [3:0] v,
                              input logic [3:0] nv, input logic eo, input logic ee);
    vec_t e;
    e.name = n; e.rst = r; e.abcd = v; e.nabcd = nv; e.exp_out = eo; e.exp_err = ee;
    tbl.push_back(e);
  endfunction

  initial begin
    logic [15:0] sweep_exp;
    logic [3:0]  v, nv;
    logic        r;
    logic        eo, ee;

    vectors     = 0;
    miscompares = 0;

    // Expected out for minterms 0..15 (bit i is minterm i): 1,0,1,1,0,1,0,1,1,0,1,1,0,1,0,1.
    sweep_exp = 16'hADAD;

    add("reset1", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    add("reset2", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);
    add("first_eval_m15", 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      add($sformatf("sweep_m%0d", i), 1'b0, 4'(i), ~4'(i), sweep_exp[i], 1'b0);
    add("dc_a_0001", 1'b0, 4'b0001, 4'b1110, 1'b0, 1'b0);
    add("dc_a_1001", 1'b0, 4'b1001, 4'b0110, 1'b0, 1'b0);
    add("dc_a_0010", 1'b0, 4'b0010, 4'b1101, 1'b1, 1'b0);
    add("dc_a_1010", 1'b0, 4'b1010, 4'b0101, 1'b1, 1'b0);
    add("bad_b_0101", 1'b0, 4'b0101, 4'b1110, 1'b0, 1'b1);
    add("restore_b_0101", 1'b0, 4'b0101, 4'b1010, 1'b1, 1'b0);
    add("bad_a_only", 1'b0, 4'b1111, 4'b1000, 1'b0, 1'b1);
    add("bad_d_low", 1'b0, 4'b0000, 4'b1110, 1'b0, 1'b1);
    add("all_bad", 1'b0, 4'b0011, 4'b0011, 1'b0, 1'b1);
    add("reset_over_bad", 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0);

    drive(1'b1, 4'b1111, 4'b0000);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].abcd, tbl[i].nabcd);
      step_check(tbl[i].name, tbl[i].exp_out, tbl[i].exp_err);
    end

    // Latency and hold: a mid-cycle input change has no effect until the next edge.
    drive(1'b0, 4'b0000, 4'b1111);
    step_check("hold_m0", 1'b1, 1'b0);
    #2;
    drive(1'b0, 4'b0100, 4'b1011);
    #2;
    check("hold_midcycle", 1'b1, 1'b0);
    step_check("hold_m4", 1'b0, 1'b0);

    // Mid-run reset at minterm 7, then resume the sweep.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'(i), ~4'(i));
      step_check($sformatf("run_m%0d", i), sweep_exp[i], 1'b0);
    end
    drive(1'b1, 4'b0111, 4'b1000);
    step_check("midrun_reset", 1'b0, 1'b0);
    for (int i = 7; i < 16; i++) begin
      drive(1'b0, 4'(i), ~4'(i));
      step_check($sformatf("resume_m%0d", i), sweep_exp[i], 1'b0);
    end

    // Randomized stimulus against the model.
    for (int n = 0; n < 300; n++) begin
      r  = ($urandom_range(15) == 0);
      v  = 4'($urandom_range(15));
      nv = ~v;
      if ($urandom_range(3) == 0) nv = nv ^ 4'($urandom_range(15));
      if (r) begin
        eo = 1'b0; ee = 1'b0;
      end else if (model_bad(v, nv)) begin
        eo = 1'b0; ee = 1'b1;
      end else begin
        eo = model_f(v); ee = 1'b0;
      end
      drive(r, v, nv);
      step_check($sformatf("rand%0d_v%b_n%b_r%0b", n, v, nv, r), eo, ee);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
